// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution controller.
// Contents: default operand width, sequential PC increment, RV32I B-type
// funct3 encodings, FSM state type and state constants.
package branch_pkg;

  localparam int          XLEN_DEF = 32;
  localparam int unsigned PC_INC   = 4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EVAL = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/br_cmp.sv
// Purely combinational XLEN-wide comparator.
// Ports:
//   a, b : operands
//   eq   : a == b
//   lt   : a < b, two's-complement signed
//   ltu  : a < b, unsigned
module br_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer for the multicycle OTTER core.
// Accepts a conditional-branch request over a valid/ready handshake,
// evaluates it one cycle later on registered operands, and presents the
// registered taken/target result over a second valid/ready handshake.
//
// State table:
//   state   | meaning
//   IDLE    | ready for a request (req_ready=1)
//   EVAL    | comparator runs on captured operands, result registered
//   RESP    | result valid, held until res_ready or flush
//
// Ports:
//   CLK, RST          : clock, async active-high reset
//   flush             : synchronous abort back to IDLE
//   req_valid/ready   : request handshake (funct3, rs1, rs2, pc, imm_b)
//   res_valid/ready   : result handshake (taken, target, illegal, misaligned)
//   taken_cnt         : saturating count of taken results consumed
//   total_cnt         : saturating count of results consumed
//
// Optional build macro BRANCH_RESOLVE_STATS_EN enables the two counters;
// without it they are tied to zero.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             illegal,
  output logic             misaligned,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  state_t            state;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, pc_q, imm_q;

  logic              eq, lt, ltu;
  logic              cond;
  logic              legal;
  logic [XLEN-1:0]   next_target;

  br_cmp #(.XLEN(XLEN)) u_cmp (
    .a   (rs1_q),
    .b   (rs2_q),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (funct3_q)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = !lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = !ltu;
      default: legal = 1'b0;
    endcase
    // Both adds wrap modulo 2^XLEN.
    next_target = cond ? (pc_q + imm_q) : (pc_q + XLEN'(PC_INC));
  end

  assign req_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_RESP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      funct3_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      taken      <= 1'b0;
      target     <= '0;
      illegal    <= 1'b0;
      misaligned <= 1'b0;
    end else if (flush) begin
      // Result registers keep their last values; they are simply invalid.
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_q <= funct3;
            rs1_q    <= rs1;
            rs2_q    <= rs2;
            pc_q     <= pc;
            imm_q    <= imm_b;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          taken      <= cond;
          target     <= next_target;
          illegal    <= !legal;
          misaligned <= cond && (next_target[1:0] != 2'b00);
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic handshake;

  // A flush in the same cycle as res_ready means the result was dropped.
  assign handshake = (state == ST_RESP) && res_ready && !flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      taken_cnt <= '0;
      total_cnt <= '0;
    end else if (handshake) begin
      if (total_cnt != {CNT_W{1'b1}}) total_cnt <= total_cnt + 1'b1;
      if (taken && (taken_cnt != {CNT_W{1'b1}})) taken_cnt <= taken_cnt + 1'b1;
    end
  end
`else
  assign taken_cnt = '0;
  assign total_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  localparam int XLEN  = 32;
  // Narrow counters so saturation is reachable in a short run.
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BRANCH_RESOLVE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1, rs2, pc, imm_b;
  logic             res_valid;
  logic             res_ready;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             illegal;
  logic             misaligned;
  logic [CNT_W-1:0] taken_cnt, total_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm_b(imm_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .taken(taken), .target(target), .illegal(illegal), .misaligned(misaligned),
    .taken_cnt(taken_cnt), .total_cnt(total_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Branch semantics straight from the ISA rules.
  function automatic void resolve(input logic [2:0] f, input logic [31:0] a, b, p, i,
                                  output logic t, output logic [31:0] tg,
                                  output logic il, output logic mi);
    int signed sa, sb;
    sa = a; sb = b;
    il = 1'b0;
    case (f)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = (sa < sb);
      3'd5: t = (sa >= sb);
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: begin t = 1'b0; il = 1'b1; end
    endcase
    tg = t ? p + i : p + 32'd4;
    mi = t && (tg[1:0] != 2'b00);
  endfunction

  // Transaction-level model: how far the current request has progressed
  // (0 waiting for a request, 1 cycle after capture, 2 result offered).
  int          m_stage;
  logic [2:0]  m_f;
  logic [31:0] m_a, m_b, m_p, m_i;
  logic        m_taken, m_ill, m_mis;
  logic [31:0] m_target;
  int          m_tc, m_tot;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stage = 0; m_f = '0; m_a = '0; m_b = '0; m_p = '0; m_i = '0;
      m_taken = 1'b0; m_target = '0; m_ill = 1'b0; m_mis = 1'b0;
      m_tc = 0; m_tot = 0;
    end else if (flush) begin
      m_stage = 0;
    end else if (m_stage == 0) begin
      if (req_valid) begin
        m_f = funct3; m_a = rs1; m_b = rs2; m_p = pc; m_i = imm_b;
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      resolve(m_f, m_a, m_b, m_p, m_i, m_taken, m_target, m_ill, m_mis);
      m_stage = 2;
    end else if (res_ready) begin
      m_tot++;
      if (m_taken) m_tc++;
      m_stage = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, m_stage == 0});
      chk("res_valid", {31'b0, res_valid}, {31'b0, m_stage == 2});
      chk("taken", {31'b0, taken}, {31'b0, m_taken});
      chk("target", target, m_target);
      chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      chk("taken_cnt", 32'(taken_cnt), STATS ? 32'((m_tc > CNT_MAX) ? CNT_MAX : m_tc) : 32'd0);
      chk("total_cnt", 32'(total_cnt), STATS ? 32'((m_tot > CNT_MAX) ? CNT_MAX : m_tot) : 32'd0);
    end
  end

  // Issue one request from an aligned point (posedge+2, IDLE), check the
  // literal result as soon as it is offered, then consume it.
  task automatic run_br(input string nm, input logic [2:0] f, input logic [31:0] a, b, p, i,
                        input logic et, input logic [31:0] etg, input logic eil, input logic emi);
    req_valid = 1'b1; funct3 = f; rs1 = a; rs2 = b; pc = p; imm_b = i;
    @(posedge clk); #2 req_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_res_valid"}, {31'b0, res_valid}, 32'd1);
    chk({nm, "_taken"}, {31'b0, taken}, {31'b0, et});
    chk({nm, "_target"}, target, etg);
    chk({nm, "_illegal"}, {31'b0, illegal}, {31'b0, eil});
    chk({nm, "_misaligned"}, {31'b0, misaligned}, {31'b0, emi});
    #1 res_ready = 1'b1;
    @(posedge clk); #2 res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm_b = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_res_valid", {31'b0, res_valid}, 32'd0);
    chk("reset_target", target, 32'd0);
    chk("reset_total_cnt", 32'(total_cnt), 32'd0);
    #1 cmp_en = 1'b1;

    run_br("beq",   3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0, 1'b0);
    run_br("blt",   3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF0, 1'b1, 32'h1F0, 1'b0, 1'b0);
    run_br("bltu",  3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF0, 1'b0, 32'h204, 1'b0, 1'b0);
    run_br("ill",   3'b010, 32'h3, 32'h3, 32'h300, 32'h40, 1'b0, 32'h304, 1'b1, 1'b0);
    run_br("wrap",  3'b001, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    run_br("misal", 3'b101, 32'h3, 32'h3, 32'h100, 32'h6, 1'b1, 32'h106, 1'b0, 1'b1);
    run_br("bgeu",  3'b111, 32'h8000_0000, 32'h1, 32'h40, 32'h8, 1'b1, 32'h48, 1'b0, 1'b0);

    // Backpressure: result held while a second request waits.
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'h9; rs2 = 32'h9; pc = 32'h500; imm_b = 32'h10;
    @(posedge clk); #2;
    funct3 = 3'b001; rs1 = 32'h1; rs2 = 32'h2; pc = 32'h400; imm_b = 32'h40;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_target", target, 32'h510);
      #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #2 res_ready = 1'b0;
    @(posedge clk); #2 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp2_res_valid", {31'b0, res_valid}, 32'd1);
    chk("bp2_target", target, 32'h440);
    #1 res_ready = 1'b1;
    @(posedge clk); #2 res_ready = 1'b0;

    // Flush during evaluation: nothing offered, back to idle.
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'h1; rs2 = 32'h1; pc = 32'h600; imm_b = 32'h4;
    @(posedge clk); #2 req_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_res_valid", {31'b0, res_valid}, 32'd0);
    chk("flush_req_ready", {31'b0, req_ready}, 32'd1);
    chk("flush_target_kept", target, 32'h440);
    #1 flush = 1'b0;

    // Reset while a result is offered.
    req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'h1; rs2 = 32'h1; pc = 32'h700; imm_b = 32'h8;
    @(posedge clk); #2 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_res_valid", {31'b0, res_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_total_cnt", 32'(total_cnt), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    #1;

    // Randomized traffic, biased toward taken so counters saturate.
    for (int n = 0; n < 4000; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      funct3    = 3'($urandom_range(0, 7));
      rs1       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rs2       = ($urandom_range(0, 1) != 0) ? rs1 : $urandom;
      pc        = $urandom;
      imm_b     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : $urandom;
      @(posedge clk); #2;
    end
    req_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("end_req_ready", {31'b0, req_ready}, 32'd1);
    chk("sat_total_cnt", 32'(total_cnt), STATS ? CNT_MAX : 32'd0);
    chk("sat_taken_cnt", 32'(taken_cnt), STATS ? CNT_MAX : 32'd0);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
